cpu_control_sequencer: RTL and testbench

//  Fetch/decode/execute controller for the 8-bit CPU; drives the program counter's load/inc/data_in from the other side.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/cpu_instr_decode.sv | 17 +
 rtl/cpu_control_sequencer.sv | 76 +++++++
 tb/tb_cpu_control_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer state encoding and A-register source codes
package cpu_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  typedef enum logic [2:0] {FETCH, DECODE, MEM, EXEC, HALT} state_t;
  typedef enum logic [1:0] {ASRC_ALU = 2'd0, ASRC_MEM = 2'd1, ASRC_IMM = 2'd2} a_src_t;
endpackage

// File: rtl/cpu_instr_decode.sv
// cpu_instr_decode: classifies an opcode into the sequencer's control categories
module cpu_instr_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       needs_mem,
  output logic       is_write,
  output logic       is_alu,
  output logic       is_jump,
  output logic       is_halt
);
  assign is_alu    = opcode == OP_ADD || opcode == OP_SUB;
  assign is_write  = opcode == OP_STA;
  assign needs_mem = is_alu || is_write || opcode == OP_LDA;
  assign is_jump   = opcode == OP_JMP || opcode == OP_JC || opcode == OP_JZ;
  assign is_halt   = opcode == OP_HLT;
endmodule

// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: fetch/decode/execute controller for the 8-bit CPU
module cpu_control_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int OPC_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_addr,
  output logic [DATA_W-1:0] ir_out,
  output logic              a_load,
  output logic [1:0]        a_src,
  output logic              b_load,
  output logic              alu_sub,
  output logic              out_load,
  output logic              halted
);
  state_t state;
  logic [OPC_W-1:0] op;
  logic needs_mem, is_write, is_alu, is_jump, is_halt;
  logic fetch_s, dec_s, mem_s, exec_s, mem_done;
  assign op = ir_out[DATA_W-1 -: OPC_W];
  cpu_instr_decode u_dec (
    .opcode   (op),
    .needs_mem(needs_mem),
    .is_write (is_write),
    .is_alu   (is_alu),
    .is_jump  (is_jump),
    .is_halt  (is_halt)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= FETCH;
      ir_out <= '0;
    end else
      case (state)
        FETCH: if (mem_ready) begin
          ir_out <= mem_rdata;
          state  <= DECODE;
        end
        DECODE: state <= is_halt ? HALT : needs_mem ? MEM : EXEC;
        MEM: if (mem_ready) state <= is_alu ? EXEC : FETCH;
        EXEC: state <= FETCH;
        default: state <= HALT;
      endcase
  // reset gates every strobe so an in-flight access is dropped immediately
  assign fetch_s  = !reset && state == FETCH;
  assign dec_s    = !reset && state == DECODE;
  assign mem_s    = !reset && state == MEM;
  assign exec_s   = !reset && state == EXEC;
  assign mem_done = mem_s && mem_ready;
  assign mem_req  = fetch_s || mem_s;
  assign mem_we   = mem_s && is_write;
  assign mem_addr = mem_s ? ir_out[ADDR_W-1:0] : pc_addr;
  assign pc_inc   = dec_s;
  assign pc_load  = exec_s && is_jump && (op == OP_JMP || (op == OP_JC ? flag_c : flag_z));
  assign pc_load_addr = ir_out[ADDR_W-1:0];
  assign a_load   = (mem_done && op == OP_LDA) || (exec_s && (is_alu || op == OP_LDI));
  assign a_src    = mem_done && op == OP_LDA ? ASRC_MEM : exec_s && op == OP_LDI ? ASRC_IMM : ASRC_ALU;
  assign b_load   = mem_done && is_alu;
  assign alu_sub  = exec_s && op == OP_SUB;
  assign out_load = exec_s && op == OP_OUT;
  assign halted   = state == HALT;
endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb_cpu_control_sequencer: random programs and memory waits checked against an instruction-level model
module tb_cpu_control_sequencer;
  logic clk = 0, reset = 0;
  logic [3:0] pc_addr = 0;
  logic [7:0] mem_rdata = 0;
  logic mem_ready = 0, flag_c = 0, flag_z = 0;
  logic mem_req, mem_we, pc_inc, pc_load, a_load, b_load, alu_sub, out_load, halted;
  logic [3:0] mem_addr, pc_load_addr;
  logic [7:0] ir_out;
  logic [1:0] a_src;
  cpu_control_sequencer dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .flag_c(flag_c), .flag_z(flag_z), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_addr(pc_load_addr), .ir_out(ir_out),
    .a_load(a_load), .a_src(a_src), .b_load(b_load), .alu_sub(alu_sub), .out_load(out_load),
    .halted(halted)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [3:0] addr; logic we; logic fetch;} acc_t;
  logic [7:0] mem [16];
  logic [7:0] ra, rb, rout;
  logic [7:0] mm [16];
  logic [7:0] ma, mout;
  logic [3:0] mpc;
  logic mc, mz, mhalt;
  acc_t exq [$];
  int checks = 0, errors = 0;
  int cyc = 0, t_last = 0, waits = 0, exp_lat = 0, ready_pct = 100;
  bit started = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic logic [8:0] alu(input logic [7:0] a, input logic [7:0] b, input logic sub);
    return sub ? {1'b0, a} + {1'b0, ~b} + 9'd1 : {1'b0, a} + {1'b0, b};
  endfunction
  // ISA-level step: executes one instruction and queues the memory accesses it must cause
  task automatic exec_model(output int lat);
    logic [7:0] ins;
    logic [8:0] s;
    logic [3:0] x;
    ins = mm[mpc];
    x = ins[3:0];
    mpc = mpc + 4'd1;
    lat = 3;
    case (ins[7:4])
      4'h1: begin ma = mm[x]; exq.push_back('{addr: x, we: 1'b0, fetch: 1'b0}); end
      4'h2, 4'h3: begin
        s = alu(ma, mm[x], ins[7:4] == 4'h3);
        ma = s[7:0]; mc = s[8]; mz = s[7:0] == 0; lat = 4;
        exq.push_back('{addr: x, we: 1'b0, fetch: 1'b0});
      end
      4'h4: begin mm[x] = ma; exq.push_back('{addr: x, we: 1'b1, fetch: 1'b0}); end
      4'h5: ma = {4'h0, x};
      4'h6: mpc = x;
      4'h7: if (mc) mpc = x;
      4'h8: if (mz) mpc = x;
      4'hE: mout = ma;
      4'hF: mhalt = 1;
      default: ;
    endcase
    if (!mhalt) exq.push_back('{addr: mpc, we: 1'b0, fetch: 1'b1});
  endtask
  task automatic tick();
    logic [7:0] n_ra, n_rb, n_rout, wd;
    logic [3:0] n_pc, wa;
    logic n_c, n_z, wr;
    logic [8:0] s;
    logic [127:0] v1, v2;
    acc_t e;
    int lat;
    @(negedge clk);
    mem_ready = $urandom_range(99) < ready_pct;
    mem_rdata = mem[mem_addr];
    #1;
    if (!mhalt) check("halted_early", halted, 0);
    else if (cyc - t_last >= 2) begin
      check("halted", halted, 1);
      check("halt_req", mem_req, 0);
    end
    if (pc_load) begin
      check("pc_inc_with_load", pc_inc, 0);
      check("pc_load_addr", pc_load_addr, ir_out[3:0]);
    end
    if (mem_req && !mem_ready) waits++;
    if (mem_req && mem_ready) begin
      if (exq.size() == 0) check("unexpected_access", mem_addr, 32'hFFFF);
      else begin
        e = exq.pop_front();
        check("acc_addr", mem_addr, e.addr);
        check("acc_we", mem_we, e.we);
        if (e.fetch) begin
          if (started) check("latency", cyc - t_last, exp_lat + waits);
          check("reg_a", ra, ma);
          check("reg_out", rout, mout);
          for (int i = 0; i < 16; i++) begin v1[i*8 +: 8] = mem[i]; v2[i*8 +: 8] = mm[i]; end
          check("mem_image", v1 == v2, 1);
          started = 1; t_last = cyc; waits = 0;
          exec_model(lat);
          exp_lat = lat;
        end
      end
    end
    n_ra = ra; n_rb = rb; n_rout = rout; n_c = flag_c; n_z = flag_z;
    wr = mem_req && mem_we && mem_ready; wa = mem_addr; wd = ra;
    if (b_load) n_rb = mem_rdata;
    if (a_load) begin
      s = alu(ra, rb, alu_sub);
      if (a_src == 2'd0) begin n_ra = s[7:0]; n_c = s[8]; n_z = s[7:0] == 0; end
      else if (a_src == 2'd1) n_ra = mem_rdata;
      else if (a_src == 2'd2) n_ra = {4'h0, ir_out[3:0]};
      else check("a_src_code", a_src, 0);
    end
    if (out_load) n_rout = ra;
    n_pc = pc_load ? pc_load_addr : pc_inc ? pc_addr + 4'd1 : pc_addr;
    @(posedge clk);
    #1;
    ra = n_ra; rb = n_rb; rout = n_rout; flag_c = n_c; flag_z = n_z; pc_addr = n_pc;
    if (wr) mem[wa] = wd;
    cyc++;
  endtask
  task automatic do_reset();
    reset = 1;
    mem_ready = 0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_ir", ir_out, 0);
    check("rst_halted", halted, 0);
    check("rst_strobes", {pc_inc, pc_load, a_load, b_load, out_load, mem_we}, 0);
    pc_addr = 0; ra = 0; rb = 0; rout = 0; flag_c = 0; flag_z = 0;
    mm = mem; ma = 0; mout = 0; mpc = 0; mc = 0; mz = 0; mhalt = 0;
    exq.delete();
    exq.push_back('{addr: 4'd0, we: 1'b0, fetch: 1'b1});
    started = 0; waits = 0;
    @(posedge clk);
    #1 reset = 0;
  endtask
  task automatic random_program();
    logic [3:0] ops [12];
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hE, 4'hF};
    for (int i = 0; i < 16; i++) mem[i] = {ops[$urandom_range(11)], 4'($urandom)};
  endtask
  initial begin
    #3;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h53; mem[1] = 8'h2A; mem[2] = 8'hE0; mem[3] = 8'h74;
    mem[4] = 8'h1B; mem[5] = 8'h2A; mem[6] = 8'h7C; mem[10] = 8'h07;
    mem[11] = 8'hFE; mem[12] = 8'h40; mem[13] = 8'hF0;
    do_reset();
    ready_pct = 100;
    for (int i = 0; i < 40; i++) tick();
    do_reset();
    ready_pct = 40;
    for (int i = 0; i < 90; i++) tick();
    do_reset();
    mem[0] = 8'h1A;
    do_reset();
    ready_pct = 100;
    tick();
    tick();
    @(negedge clk);
    mem_ready = 0;
    #1;
    check("lda_mem_req", mem_req, 1);
    check("lda_mem_addr", mem_addr, 4'hA);
    check("lda_wait_aload", a_load, 0);
    #1 mem_ready = 1;
    #1;
    check("lda_aload", a_load, 1);
    check("lda_asrc", a_src, 1);
    #1;
    do_reset();
    for (int p = 0; p < 12; p++) begin
      random_program();
      do_reset();
      ready_pct = $urandom_range(30, 100);
      for (int i = 0; i < 300; i++) tick();
      #($urandom_range(0, 7));
    end
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
